// File: rtl/csr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : csr_arbiter
// Description : Round-robin arbiter that muxes n_masters requesters onto one
//               CSR bus; each transaction takes four cycles.
// Revision    : 1.0
// ============================================================================

module csr_arbiter #(
    parameter int n_masters = 2
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [n_masters-1:0]    m_stb,
    input  logic [n_masters-1:0]    m_we,
    input  logic [14*n_masters-1:0] m_adr,
    input  logic [8*n_masters-1:0]  m_dat_w,
    output logic [n_masters-1:0]    m_ack,
    output logic [7:0]              m_dat_r,
    output logic [13:0]             csr_adr,
    output logic                    csr_we,
    output logic [7:0]              csr_dat_w,
    input  logic [7:0]              csr_dat_r
);

    localparam int c_gw = (n_masters > 1) ? $clog2(n_masters) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_READ   = 2'd2,
        S_ACK    = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [c_gw-1:0] r_grant;
    logic [c_gw-1:0] r_last;
    logic [c_gw-1:0] w_winner;
    logic            w_hit;
    logic            w_start;
    logic [13:0]     w_adr_sel;
    logic [7:0]      w_dat_sel;
    logic            w_we_sel;

    assign w_start = (r_state == S_IDLE) && (|m_stb);

    // Walk from the farthest candidate to the nearest so the nearest requester
    // after the last grant ends up as the winner.
    always_comb begin
        w_winner = r_last;
        w_hit    = 1'b0;
        for (int k = n_masters; k >= 1; k--) begin
            w_hit = 1'(m_stb >> ((int'(r_last) + k) % n_masters));
            if (w_hit) begin
                w_winner = c_gw'((int'(r_last) + k) % n_masters);
            end
        end
    end

    assign w_adr_sel = 14'(m_adr >> (14 * int'(w_winner)));
    assign w_dat_sel = 8'(m_dat_w >> (8 * int'(w_winner)));
    assign w_we_sel  = 1'(m_we >> w_winner);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (|m_stb) w_state_next = S_ACCESS;
            S_ACCESS: w_state_next = S_READ;
            S_READ:   w_state_next = S_ACK;
            S_ACK:    w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_grant   <= '0;
            r_last    <= c_gw'(n_masters - 1);
            m_ack     <= '0;
            m_dat_r   <= '0;
            csr_adr   <= '0;
            csr_we    <= 1'b0;
            csr_dat_w <= '0;
        end else begin
            m_ack  <= '0;
            csr_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_grant   <= w_winner;
                        r_last    <= w_winner;
                        csr_adr   <= w_adr_sel;
                        csr_we    <= w_we_sel;
                        csr_dat_w <= w_dat_sel;
                    end
                end
                S_READ: begin
                    // The slave registers its read data, so it is valid here.
                    m_dat_r <= csr_dat_r;
                    m_ack   <= n_masters'(1) << r_grant;
                end
                S_ACK: begin
                    csr_adr   <= '0;
                    csr_dat_w <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_csr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_arbiter
// Description : Self-checking bench for csr_arbiter (2- and 4-master builds).
// Revision    : 1.0
// ============================================================================

module tb_csr_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [1:0]  a_stb, a_we, a_ack;
    logic [27:0] a_adr;
    logic [15:0] a_dw;
    logic [7:0]  a_dr, a_csr_dw, a_csr_dr;
    logic [13:0] a_csr_adr;
    logic        a_csr_we;
    logic        a_ovr;
    logic [7:0]  a_ovr_val;

    logic [3:0]  b_stb, b_we, b_ack;
    logic [55:0] b_adr;
    logic [31:0] b_dw;
    logic [7:0]  b_dr, b_csr_dw, b_csr_dr;
    logic [13:0] b_csr_adr;
    logic        b_csr_we;

    csr_arbiter #(.n_masters(2)) dut_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .m_stb(a_stb), .m_we(a_we),
        .m_adr(a_adr), .m_dat_w(a_dw), .m_ack(a_ack), .m_dat_r(a_dr),
        .csr_adr(a_csr_adr), .csr_we(a_csr_we), .csr_dat_w(a_csr_dw),
        .csr_dat_r(a_csr_dr)
    );

    csr_arbiter #(.n_masters(4)) dut_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .m_stb(b_stb), .m_we(b_we),
        .m_adr(b_adr), .m_dat_w(b_dw), .m_ack(b_ack), .m_dat_r(b_dr),
        .csr_adr(b_csr_adr), .csr_we(b_csr_we), .csr_dat_w(b_csr_dw),
        .csr_dat_r(b_csr_dr)
    );

    function automatic logic [7:0] slave_fn(input logic [13:0] a);
        return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h3C;
    endfunction

    // Registered slaves: read data follows the address by one cycle.
    always @(posedge clk) begin
        a_csr_dr <= a_ovr ? a_ovr_val : slave_fn(a_csr_adr);
        b_csr_dr <= slave_fn(b_csr_adr);
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (a_ack !== 2'b00) begin $display("FAIL reset_a_ack: got %b want 00", a_ack); errors++; end
        checks++; if (a_dr !== 8'h00) begin $display("FAIL reset_a_dat_r: got %h want 00", a_dr); errors++; end
        checks++; if (a_csr_adr !== 14'h0) begin $display("FAIL reset_a_csr_adr: got %h want 0", a_csr_adr); errors++; end
        checks++; if (a_csr_we !== 1'b0) begin $display("FAIL reset_a_csr_we: got %b want 0", a_csr_we); errors++; end
        checks++; if (a_csr_dw !== 8'h00) begin $display("FAIL reset_a_csr_dat_w: got %h want 00", a_csr_dw); errors++; end
        checks++; if (b_ack !== 4'b0000) begin $display("FAIL reset_b_ack: got %b want 0000", b_ack); errors++; end
        checks++; if (b_dr !== 8'h00) begin $display("FAIL reset_b_dat_r: got %h want 00", b_dr); errors++; end
        checks++; if (b_csr_adr !== 14'h0) begin $display("FAIL reset_b_csr_adr: got %h want 0", b_csr_adr); errors++; end
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        a_ovr = 1'b1; a_ovr_val = 8'h5A;
        a_adr[13:0] = 14'h0123; a_we = 2'b00; a_stb = 2'b01;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++; if (a_ack !== ((k == 3) ? 2'b01 : 2'b00)) begin $display("FAIL read_ack t+%0d: got %b", k, a_ack); errors++; end
            checks++; if (a_csr_we !== 1'b0) begin $display("FAIL read_we t+%0d: got %b want 0", k, a_csr_we); errors++; end
            if (k <= 2) begin
                checks++; if (a_csr_adr !== 14'h0123) begin $display("FAIL read_adr t+%0d: got %h want 0123", k, a_csr_adr); errors++; end
            end
            if (k == 4) begin
                checks++; if (a_csr_adr !== 14'h0) begin $display("FAIL read_adr_idle: got %h want 0", a_csr_adr); errors++; end
            end
            if (k >= 3) begin
                checks++; if (a_dr !== 8'h5A) begin $display("FAIL read_dat_r t+%0d: got %h want 5a", k, a_dr); errors++; end
            end
            if (k == 3) a_stb = 2'b00;
        end
        a_ovr = 1'b0;
    endtask

    task automatic test_single_write();
        a_adr[27:14] = 14'h3FFF; a_dw[15:8] = 8'hA5; a_we = 2'b10; a_stb = 2'b10;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++; if (a_csr_we !== (k == 1)) begin $display("FAIL write_we t+%0d: got %b", k, a_csr_we); errors++; end
            checks++; if (a_ack !== ((k == 3) ? 2'b10 : 2'b00)) begin $display("FAIL write_ack t+%0d: got %b", k, a_ack); errors++; end
            if (k == 1) begin
                checks++; if (a_csr_adr !== 14'h3FFF) begin $display("FAIL write_adr: got %h want 3fff", a_csr_adr); errors++; end
                checks++; if (a_csr_dw !== 8'hA5) begin $display("FAIL write_dat_w: got %h want a5", a_csr_dw); errors++; end
            end
            if (k == 3) begin
                checks++; if (a_dr !== slave_fn(14'h3FFF)) begin $display("FAIL write_dat_r: got %h want %h", a_dr, slave_fn(14'h3FFF)); errors++; end
                a_stb = 2'b00; a_we = 2'b00;
            end
        end
    endtask

    task automatic test_contention();
        logic [1:0]  exp_ack;
        logic [13:0] exp_adr;
        rst_n = 1'b0;
        a_stb = 2'b11; a_we = 2'b00; a_adr = {14'h0222, 14'h0111};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp_ack = (k % 4 == 3) ? (((k / 4) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            checks++; if (a_ack !== exp_ack) begin $display("FAIL contention_ack cyc %0d: got %b want %b", k, a_ack, exp_ack); errors++; end
            if (k % 4 == 1) begin
                exp_adr = (((k / 4) % 2) == 0) ? 14'h0111 : 14'h0222;
                checks++; if (a_csr_adr !== exp_adr) begin $display("FAIL contention_adr cyc %0d: got %h want %h", k, a_csr_adr, exp_adr); errors++; end
            end
        end
        a_stb = 2'b00;
    endtask

    task automatic test_mid_reset();
        a_stb = 2'b01; a_we = 2'b01; a_adr[13:0] = 14'h0055; a_dw[7:0] = 8'h77;
        @(negedge clk);
        checks++; if (a_csr_we !== 1'b1) begin $display("FAIL midrst_access_we: got %b want 1", a_csr_we); errors++; end
        @(negedge clk);
        rst_n = 1'b0; a_stb = 2'b00; a_we = 2'b00;
        #1;
        checks++; if (a_csr_adr !== 14'h0) begin $display("FAIL midrst_adr: got %h want 0", a_csr_adr); errors++; end
        checks++; if (a_csr_we !== 1'b0) begin $display("FAIL midrst_we: got %b want 0", a_csr_we); errors++; end
        checks++; if (a_csr_dw !== 8'h00) begin $display("FAIL midrst_dat_w: got %h want 00", a_csr_dw); errors++; end
        checks++; if (a_dr !== 8'h00) begin $display("FAIL midrst_dat_r: got %h want 00", a_dr); errors++; end
        checks++; if (a_ack !== 2'b00) begin $display("FAIL midrst_ack: got %b want 00", a_ack); errors++; end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++; if (a_ack !== 2'b00 || a_csr_we !== 1'b0 || a_csr_adr !== 14'h0) begin
                $display("FAIL midrst_after cyc %0d: ack=%b we=%b adr=%h want 00/0/0", k, a_ack, a_csr_we, a_csr_adr); errors++;
            end
        end
    endtask

    task automatic test_field_change();
        a_stb = 2'b01; a_we = 2'b00; a_adr[13:0] = 14'h0010;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k <= 2) begin
                checks++; if (a_csr_adr !== 14'h0010) begin $display("FAIL field_adr t+%0d: got %h want 0010", k, a_csr_adr); errors++; end
            end
            if (k == 1) a_adr[13:0] = 14'h0020;
            if (k == 3) begin
                checks++; if (a_ack !== 2'b01) begin $display("FAIL field_ack: got %b want 01", a_ack); errors++; end
                checks++; if (a_dr !== slave_fn(14'h0010)) begin $display("FAIL field_dat_r: got %h want %h", a_dr, slave_fn(14'h0010)); errors++; end
                a_stb = 2'b00;
            end
            if (k == 4) begin
                checks++; if (a_csr_adr !== 14'h0) begin $display("FAIL field_adr_idle: got %h want 0", a_csr_adr); errors++; end
            end
        end
    endtask

    task automatic test_fairness();
        logic [3:0]  exp_ack;
        logic [13:0] exp_adr;
        b_adr = {14'h0444, 14'h0333, 14'h0222, 14'h0111}; b_we = 4'b0000; b_stb = 4'b1111;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            exp_ack = (k % 4 == 3) ? (4'b0001 << ((k / 4) % 4)) : 4'b0000;
            checks++; if (b_ack !== exp_ack) begin $display("FAIL fair_ack cyc %0d: got %b want %b", k, b_ack, exp_ack); errors++; end
            if (k % 4 == 1) begin
                exp_adr = 14'((((k / 4) % 4) + 1) * 14'h111);
                checks++; if (b_csr_adr !== exp_adr) begin $display("FAIL fair_adr cyc %0d: got %h want %h", k, b_csr_adr, exp_adr); errors++; end
            end
        end
        b_stb = 4'b0000;
    endtask

    // Transaction timeline model: phase counts cycles since the grant edge.
    task automatic test_random();
        int          ph = 0;
        int          last = 3;
        int          win = 0;
        int          c;
        bit          found;
        bit          pend [4];
        logic [13:0] ladr = '0;
        logic        lwe = 1'b0;
        logic [7:0]  ldw = '0;
        logic [7:0]  mdr = '0;
        logic [3:0]  exp_ack;
        rst_n = 1'b0; b_stb = 4'b0000;
        for (int i = 0; i < 4; i++) pend[i] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            exp_ack = (ph == 3) ? (4'b0001 << win) : 4'b0000;
            checks++; if (b_ack !== exp_ack) begin $display("FAIL rand_ack cyc %0d: got %b want %b", cyc, b_ack, exp_ack); errors++; end
            checks++; if (b_csr_we !== ((ph == 1) ? lwe : 1'b0)) begin $display("FAIL rand_we cyc %0d: got %b", cyc, b_csr_we); errors++; end
            checks++; if (b_csr_adr !== ((ph == 0) ? 14'h0 : ladr)) begin $display("FAIL rand_adr cyc %0d: got %h want %h", cyc, b_csr_adr, (ph == 0) ? 14'h0 : ladr); errors++; end
            checks++; if (b_dr !== mdr) begin $display("FAIL rand_dat_r cyc %0d: got %h want %h", cyc, b_dr, mdr); errors++; end
            if (ph <= 1) begin
                checks++; if (b_csr_dw !== ((ph == 1) ? ldw : 8'h00)) begin $display("FAIL rand_dat_w cyc %0d: got %h", cyc, b_csr_dw); errors++; end
            end
            for (int i = 0; i < 4; i++) begin
                if (pend[i] && ph == 3 && win == i) begin
                    pend[i] = 1'b0; b_stb[i] = 1'b0;
                end else if (pend[i] && (ph == 1 || ph == 2) && win == i && $urandom_range(0, 1) == 1) begin
                    b_adr[14*i +: 14] = 14'($urandom); b_we[i] = 1'($urandom); b_dw[8*i +: 8] = 8'($urandom);
                end else if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1; b_stb[i] = 1'b1;
                    b_adr[14*i +: 14] = 14'($urandom); b_we[i] = 1'($urandom); b_dw[8*i +: 8] = 8'($urandom);
                end
            end
            case (ph)
                0: if (b_stb != 4'b0000) begin
                    found = 1'b0;
                    for (int k = 1; k <= 4; k++) begin
                        c = (last + k) % 4;
                        if (!found && b_stb[c]) begin win = c; found = 1'b1; end
                    end
                    last = win;
                    ladr = b_adr[14*win +: 14]; lwe = b_we[win]; ldw = b_dw[8*win +: 8];
                    ph = 1;
                end
                1: ph = 2;
                2: begin mdr = slave_fn(ladr); ph = 3; end
                default: ph = 0;
            endcase
        end
        b_stb = 4'b0000;
    endtask

    initial begin
        rst_n = 1'b0;
        a_stb = '0; a_we = '0; a_adr = '0; a_dw = '0; a_ovr = 1'b0; a_ovr_val = '0;
        b_stb = '0; b_we = '0; b_adr = '0; b_dw = '0;
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_mid_reset();
        test_field_change();
        test_fairness();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/csr_arbiter.md
CSR_ARBITER -- requirements
Module: csr_arbiter

Interface
REQ-001 Parameter n_masters, default 2, number of CSR bus requesters (range 1..8).
REQ-002 sys_clk  input  1  single clock; every register is clocked on its rising edge.
REQ-003 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 m_stb  input  n_masters  per-master request; master i uses bit i.
REQ-005 m_we  input  n_masters  per-master write enable; 1 = write, 0 = read.
REQ-006 m_adr  input  14*n_masters  per-master CSR address; master i uses bits [14*i+13:14*i].
REQ-007 m_dat_w  input  8*n_masters  per-master write data; master i uses bits [8*i+7:8*i].
REQ-008 m_ack  output  n_masters  per-master one-cycle completion pulse.
REQ-009 m_dat_r  output  8  read data, shared by all masters, valid while any m_ack bit is high.
REQ-010 csr_adr  output  14  CSR bus address.
REQ-011 csr_we  output  1  CSR bus write strobe.
REQ-012 csr_dat_w  output  8  CSR bus write data.
REQ-013 csr_dat_r  input  8  CSR bus read data; the slave registers it, so it is valid one cycle after csr_adr is presented.

Function
REQ-014 FSM states IDLE, ACCESS, READ, ACK; transitions IDLE->ACCESS (any m_stb high), ACCESS->READ, READ->ACK, ACK->IDLE; all other transitions are forbidden.
REQ-015 IDLE with no m_stb bit high: remain IDLE; csr_adr=0, csr_we=0, csr_dat_w=0.
REQ-016 IDLE with m_stb nonzero: register the round-robin winner index into grant, and register its m_adr, m_we and m_dat_w into csr_adr, csr_we and csr_dat_w.
REQ-017 Round-robin priority: search order is last+1, last+2, ... modulo n_masters, where last is the most recently granted index; last updates to the winner at each grant.
REQ-018 ACCESS (cycle t+1 after the request is sampled in cycle t): csr_adr, csr_we and csr_dat_w carry the latched request; csr_we is high for exactly this one cycle, and only for writes.
REQ-019 READ (t+2): csr_adr holds the latched value; csr_we=0; csr_dat_r is captured into m_dat_r at the end of this cycle.
REQ-020 ACK (t+3): m_ack[grant]=1 for exactly one cycle; all other m_ack bits are 0; m_dat_r holds the captured byte; csr_adr returns to 0 at the next edge.
REQ-021 m_dat_r is captured for writes as well; its value on a write ack is undefined to masters, but it is deterministic (the csr_dat_r sampled in READ).
REQ-022 m_dat_r holds its value outside ACK until the next capture.
REQ-023 Request latency from m_stb sampled to m_ack is 3 cycles; back-to-back throughput is one transaction per 4 cycles, with the next grant decided in IDLE at t+4.
REQ-024 Request values are latched at grant; changes to the granted master's m_adr, m_we, m_dat_w or m_stb after grant are ignored, and its ack is still issued.
REQ-025 A master holds m_stb and its request fields stable until ack, then deasserts m_stb no later than the cycle after ack; m_stb still high in IDLE after that is treated as a new request.
REQ-026 Non-granted requests wait without loss; no master waits more than n_masters-1 transactions once its m_stb is high (starvation-free).
REQ-027 With n_masters=1, arbitration degenerates to always granting master 0; timing is unchanged.

Reset
REQ-028 sys_rst_n low asynchronously forces: state=IDLE, grant=0, last=n_masters-1 (master 0 highest priority first), m_ack=0, m_dat_r=0, csr_adr=0, csr_we=0, csr_dat_w=0.
REQ-029 Reset asserted mid-transaction aborts it: no ack is issued for it, and no csr_we pulse occurs after reset assertion.
REQ-030 Exit from reset is synchronous to sys_clk; the first grant can occur in the first IDLE cycle after release.

Verification
REQ-031 Single read: m_stb=01, m_we=0, m_adr[0]=0x0123, slave returns 0x5A -> csr_adr=0x0123 at t+1 and t+2, csr_we=0 throughout, m_ack=01 at t+3 only, m_dat_r=0x5A.
REQ-032 Single write: master 1 writes 0xA5 to 0x3FFF -> csr_we=1 only at t+1, with csr_adr=0x3FFF and csr_dat_w=0xA5; m_ack=10 at t+3.
REQ-033 Contention: n_masters=2, m_stb=11 held from reset release -> grants alternate 0,1,0,1; acks spaced 4 cycles apart.
REQ-034 Fairness: n_masters=4, m_stb=1111 held continuously -> grant order 0,1,2,3,0; each master is acked once per 16 cycles.
REQ-035 Mid-transaction reset: assert sys_rst_n=0 during READ of a write -> all outputs are 0 immediately, no m_ack, state IDLE after release.
REQ-036 Field change after grant: change m_adr[0] from 0x0010 to 0x0020 in ACCESS -> csr_adr stays 0x0010 through READ.
